// File: rtl/cep_pkg_serializer_if.sv
// Handshake bundle between the CEP encoder, the packet serializer and the link
// transmitter.
//   master : serializer side. It accepts packets (pkg_rdy) and drives flits.
//   slave  : environment side. It drives packets (pkg_val/pkg_data) and
//            applies link backpressure (flit_rdy).
// Signals: pkg_val, pkg_data[PKG_WIDTH], pkg_rdy, flit_val,
//          flit_data[FLIT_WIDTH], flit_first, flit_last, flit_rdy.
interface cep_pkg_serializer_if #(
  parameter int PKG_WIDTH  = 512,
  parameter int FLIT_WIDTH = 64
);
  logic                  pkg_val;
  logic [PKG_WIDTH-1:0]  pkg_data;
  logic                  pkg_rdy;
  logic                  flit_val;
  logic [FLIT_WIDTH-1:0] flit_data;
  logic                  flit_first;
  logic                  flit_last;
  logic                  flit_rdy;

  modport master (
    input  pkg_val, pkg_data, flit_rdy,
    output pkg_rdy, flit_val, flit_data, flit_first, flit_last
  );

  modport slave (
    output pkg_val, pkg_data, flit_rdy,
    input  pkg_rdy, flit_val, flit_data, flit_first, flit_last
  );
endinterface

// File: rtl/cep_pkg_serializer.sv
// Splits each wide CEP packet into NUM_FLITS narrow flits for the inter-chip
// link. The low word goes out first, so flit 0 carries the header fields.
// Back-to-back packets stream without bubbles: the next packet loads in the
// same cycle that the final flit of the current packet leaves.
//
// Optional feature: define CEP_SER_CHKSUM_EN to append one checksum flit to
// every packet. The checksum is the XOR of all the data flits.
//
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : cep_pkg_serializer_if.master (packet side and flit side)
//
// state | meaning
// IDLE  | no packet held; pkg_rdy=1
// SEND  | presenting data flit flit_idx from shift_q
// CHK   | presenting the checksum flit (CEP_SER_CHKSUM_EN only)
module cep_pkg_serializer #(
  parameter int PKG_WIDTH  = 512,
  parameter int FLIT_WIDTH = 64,
  parameter int NUM_FLITS  = PKG_WIDTH / FLIT_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  cep_pkg_serializer_if.master bus
);
  localparam int IDX_W = $clog2(NUM_FLITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FLITS - 1);

`ifdef CEP_SER_CHKSUM_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_CHK} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SEND} state_t;
`endif

  state_t                state_q, state_nxt;
  logic [PKG_WIDTH-1:0]  shift_q;
  logic [IDX_W-1:0]      flit_idx_q;
`ifdef CEP_SER_CHKSUM_EN
  logic [FLIT_WIDTH-1:0] csum_q;
`endif

  logic                  load, shift_en, is_last_data;
  logic                  flit_val_i, flit_first_i, flit_last_i;
  logic [FLIT_WIDTH-1:0] flit_data_i;

  always_comb begin
    state_nxt    = state_q;
    load         = 1'b0;
    shift_en     = 1'b0;
    flit_val_i   = 1'b0;
    flit_first_i = 1'b0;
    flit_last_i  = 1'b0;
    flit_data_i  = '0;
    is_last_data = (flit_idx_q == LAST_IDX);
    case (state_q)
      ST_IDLE: begin
        if (bus.pkg_val) begin
          load      = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        flit_val_i   = 1'b1;
        flit_data_i  = shift_q[FLIT_WIDTH-1:0];
        flit_first_i = (flit_idx_q == '0);
`ifndef CEP_SER_CHKSUM_EN
        flit_last_i  = is_last_data;
`endif
        if (bus.flit_rdy) begin
          shift_en = 1'b1;
          if (is_last_data) begin
`ifdef CEP_SER_CHKSUM_EN
            state_nxt = ST_CHK;
`else
            if (bus.pkg_val) begin
              load      = 1'b1;
              state_nxt = ST_SEND;
            end else begin
              state_nxt = ST_IDLE;
            end
`endif
          end
        end
      end
`ifdef CEP_SER_CHKSUM_EN
      ST_CHK: begin
        flit_val_i  = 1'b1;
        flit_data_i = csum_q;
        flit_last_i = 1'b1;
        if (bus.flit_rdy) begin
          if (bus.pkg_val) begin
            load      = 1'b1;
            state_nxt = ST_SEND;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Load has priority over shift: on the final-flit cycle the new packet
  // replaces the drained shift register and restarts index and checksum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      flit_idx_q <= '0;
`ifdef CEP_SER_CHKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q <= state_nxt;
      if (load) begin
        shift_q    <= bus.pkg_data;
        flit_idx_q <= '0;
`ifdef CEP_SER_CHKSUM_EN
        csum_q     <= '0;
`endif
      end else if (shift_en) begin
        shift_q    <= shift_q >> FLIT_WIDTH;
        flit_idx_q <= flit_idx_q + IDX_W'(1);
`ifdef CEP_SER_CHKSUM_EN
        csum_q     <= csum_q ^ shift_q[FLIT_WIDTH-1:0];
`endif
      end
    end
  end

  // Outputs are forced low while reset is asserted. pkg_rdy depends
  // combinationally on flit_rdy so a new packet can follow the final flit
  // without a bubble.
  assign bus.pkg_rdy    = rst_n & ((state_q == ST_IDLE) | (flit_last_i & bus.flit_rdy));
  assign bus.flit_val   = rst_n & flit_val_i;
  assign bus.flit_first = rst_n & flit_first_i;
  assign bus.flit_last  = rst_n & flit_last_i;
  assign bus.flit_data  = rst_n ? flit_data_i : '0;
endmodule

// File: tb/tb_cep_pkg_serializer.sv
module tb_cep_pkg_serializer;
`ifdef CEP_SER_CHKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif
  localparam int TOT_A = 8 + CHK;
  localparam int TOT_B = 4 + CHK;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cep_pkg_serializer_if #(.PKG_WIDTH(512), .FLIT_WIDTH(64))  bus_a ();
  cep_pkg_serializer_if #(.PKG_WIDTH(512), .FLIT_WIDTH(128)) bus_b ();

  cep_pkg_serializer #(.PKG_WIDTH(512), .FLIT_WIDTH(64)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  cep_pkg_serializer #(.PKG_WIDTH(512), .FLIT_WIDTH(128)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference flit i of a packet cut into nf flits of fw bits; index nf is
  // the XOR checksum of the data flits.
  function automatic logic [127:0] exp_flit(input logic [511:0] pkt, input int fw,
                                            input int nf, input int i);
    logic [511:0] tmp;
    logic [127:0] acc;
    acc = '0;
    if (i < nf) begin
      tmp = pkt >> (fw * i);
      acc = (fw == 64) ? {64'b0, tmp[63:0]} : tmp[127:0];
    end else begin
      for (int k = 0; k < nf; k++) acc ^= exp_flit(pkt, fw, nf, k);
    end
    return acc;
  endfunction

  // Expects flits 0..TOT_A-1 of pkt on bus_a, flit 0 already presented.
  task automatic recv_a(input logic [511:0] pkt, input string tag);
    for (int i = 0; i < TOT_A; i++) begin
      @(negedge clk);
      check_val($sformatf("%s_val%0d", tag, i), 128'(bus_a.flit_val), 128'(1));
      check_val($sformatf("%s_data%0d", tag, i), 128'(bus_a.flit_data), exp_flit(pkt, 64, 8, i));
      check_val($sformatf("%s_first%0d", tag, i), 128'(bus_a.flit_first), 128'(i == 0));
      check_val($sformatf("%s_last%0d", tag, i), 128'(bus_a.flit_last), 128'(i == TOT_A - 1));
      @(posedge clk); #1;
    end
  endtask

  // Presents pkt on bus_a, expects immediate acceptance, then drops it.
  task automatic offer_a(input logic [511:0] pkt, input string tag);
    bus_a.pkg_val  = 1'b1;
    bus_a.pkg_data = pkt;
    @(negedge clk);
    check_val({tag, "_acc_rdy"}, 128'(bus_a.pkg_rdy), 128'(1));
    @(posedge clk); #1;
    bus_a.pkg_val  = 1'b0;
    bus_a.pkg_data = '0;
  endtask

  logic [511:0] p1, p2, p3, p4, pa;

  initial begin
    for (int i = 0; i < 8; i++) begin
      p1[64*i +: 64] = 64'h1111_0000_0000_0000 * 64'(i + 1);
      p2[64*i +: 64] = {32'hDEAD_0000 + 32'(i), 32'h0000_BEEF ^ 32'(i)};
      p3[64*i +: 64] = {8{8'h10 + 8'(i)}};
      p4[64*i +: 64] = {16'h4000 + 16'(i), 48'h0123_4567_89AB};
    end
    pa = {16{32'hAAAA_AAAA}};

    rst_n = 1'b0;
    bus_a.pkg_val = 1'b0; bus_a.pkg_data = '0; bus_a.flit_rdy = 1'b1;
    bus_b.pkg_val = 1'b0; bus_b.pkg_data = '0; bus_b.flit_rdy = 1'b1;

    // Reset: everything low, pkg_rdy gated.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_pkg_rdy", 128'(bus_a.pkg_rdy), 128'(0));
    check_val("rst_flit_val", 128'(bus_a.flit_val), 128'(0));
    check_val("rst_flit_data", 128'(bus_a.flit_data), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_pkg_rdy", 128'(bus_a.pkg_rdy), 128'(1));
    check_val("post_rst_flit_val", 128'(bus_a.flit_val), 128'(0));
    @(posedge clk); #1;

    // Single packet, flit_rdy held high.
    offer_a(p1, "p1");
    recv_a(p1, "p1");
    @(negedge clk);
    check_val("p1_idle_val", 128'(bus_a.flit_val), 128'(0));
    check_val("p1_idle_rdy", 128'(bus_a.pkg_rdy), 128'(1));
    @(posedge clk); #1;

    // Back-to-back packets: no idle cycle, pkg_rdy pulses on each last flit.
    bus_a.pkg_val  = 1'b1;
    bus_a.pkg_data = p2;
    @(negedge clk);
    check_val("b2b_acc_rdy", 128'(bus_a.pkg_rdy), 128'(1));
    @(posedge clk); #1;
    bus_a.pkg_data = p3;
    for (int i = 0; i < 2 * TOT_A; i++) begin
      @(negedge clk);
      check_val($sformatf("b2b_val%0d", i), 128'(bus_a.flit_val), 128'(1));
      check_val($sformatf("b2b_data%0d", i), 128'(bus_a.flit_data),
                exp_flit((i < TOT_A) ? p2 : p3, 64, 8, i % TOT_A));
      check_val($sformatf("b2b_first%0d", i), 128'(bus_a.flit_first), 128'(i % TOT_A == 0));
      check_val($sformatf("b2b_rdy%0d", i), 128'(bus_a.pkg_rdy), 128'(i % TOT_A == TOT_A - 1));
      @(posedge clk); #1;
      if (i == TOT_A - 1) begin
        bus_a.pkg_val  = 1'b0;
        bus_a.pkg_data = '0;
      end
    end
    @(negedge clk);
    check_val("b2b_idle_val", 128'(bus_a.flit_val), 128'(0));
    @(posedge clk); #1;

    // Backpressure at flit 3, plus a packet waiting from flit 2 onward.
    offer_a(p4, "p4");
    for (int i = 0; i < TOT_A; i++) begin
      if (i == 2) begin
        bus_a.pkg_val  = 1'b1;
        bus_a.pkg_data = pa;
      end
      if (i == 3) begin
        bus_a.flit_rdy = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check_val($sformatf("bp_hold_data%0d", s), 128'(bus_a.flit_data), exp_flit(p4, 64, 8, 3));
          check_val($sformatf("bp_hold_val%0d", s), 128'(bus_a.flit_val), 128'(1));
          check_val($sformatf("bp_hold_rdy%0d", s), 128'(bus_a.pkg_rdy), 128'(0));
          @(posedge clk); #1;
        end
        bus_a.flit_rdy = 1'b1;
      end
      @(negedge clk);
      check_val($sformatf("bp_data%0d", i), 128'(bus_a.flit_data), exp_flit(p4, 64, 8, i));
      check_val($sformatf("bp_last%0d", i), 128'(bus_a.flit_last), 128'(i == TOT_A - 1));
      check_val($sformatf("bp_rdy%0d", i), 128'(bus_a.pkg_rdy), 128'(i == TOT_A - 1));
      @(posedge clk); #1;
    end
    bus_a.pkg_val  = 1'b0;
    bus_a.pkg_data = '0;
    recv_a(pa, "pa");

    // Reset while flit 5 is presented.
    offer_a(p1, "mr");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_val("mr_before_data", 128'(bus_a.flit_data), exp_flit(p1, 64, 8, 5));
    #4;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("mr_val", 128'(bus_a.flit_val), 128'(0));
    check_val("mr_data", 128'(bus_a.flit_data), 128'(0));
    check_val("mr_first", 128'(bus_a.flit_first), 128'(0));
    check_val("mr_last", 128'(bus_a.flit_last), 128'(0));
    check_val("mr_pkg_rdy", 128'(bus_a.pkg_rdy), 128'(1));
    @(posedge clk); #1;
    offer_a(p2, "mr_new");
    recv_a(p2, "mr_new");

    // 128-bit flits: 4 data flits per packet.
    bus_b.pkg_val  = 1'b1;
    bus_b.pkg_data = p1;
    @(negedge clk);
    check_val("w128_acc_rdy", 128'(bus_b.pkg_rdy), 128'(1));
    @(posedge clk); #1;
    bus_b.pkg_val  = 1'b0;
    bus_b.pkg_data = '0;
    for (int i = 0; i < TOT_B; i++) begin
      @(negedge clk);
      check_val($sformatf("w128_val%0d", i), 128'(bus_b.flit_val), 128'(1));
      check_val($sformatf("w128_data%0d", i), bus_b.flit_data, exp_flit(p1, 128, 4, i));
      check_val($sformatf("w128_first%0d", i), 128'(bus_b.flit_first), 128'(i == 0));
      check_val($sformatf("w128_last%0d", i), 128'(bus_b.flit_last), 128'(i == TOT_B - 1));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_val("w128_idle_val", 128'(bus_b.flit_val), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
